// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load handshake.
// Streams WIDTH-bit words one bit per clock, back-to-back without gaps.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             at_last;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    // Handshake qualifiers: a new word may land while the last bit is out.
    always_comb begin
        at_last    = (state_q == SHIFT) && (cnt_q == LAST);
        load_ready = (state_q == IDLE) || at_last;
        accept     = load_valid && load_ready;
    end

    // Move the next bit toward the output end, zero filling behind it.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = sreg_q << 1;
        end else begin
            sreg_shifted = sreg_q >> 1;
        end
    end

    // Next-state logic for FSM, shift register and bit counter.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = parallel_in;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + 1'b1;
                end else if (accept) begin
                    sreg_d = parallel_in;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial outputs derive from state only, so they clear with reset.
    always_comb begin
        serial_valid = (state_q == SHIFT);
        last_bit     = at_last;
        serial_out   = 1'b0;
        if (state_q == SHIFT) begin
            serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances
// driven in lockstep, plus a 4-bit left-shifting SIPO on the MSB stream.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] parallel_in = 4'b0000;

    logic m_ready, m_out, m_valid, m_last;
    logic l_ready, l_out, l_valid, l_last;

    logic [3:0] sipo_q;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (m_ready),
        .parallel_in  (parallel_in),
        .serial_out   (m_out),
        .serial_valid (m_valid),
        .last_bit     (m_last)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (l_ready),
        .parallel_in  (parallel_in),
        .serial_out   (l_out),
        .serial_valid (l_valid),
        .last_bit     (l_last)
    );

    // Downstream SIPO, capture qualified by serial_valid.
    always @(posedge clk or negedge rst) begin
        if (!rst) sipo_q <= 4'b0000;
        else if (m_valid) sipo_q <= {sipo_q[2:0], m_out};
    end

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // exp = {serial_out, serial_valid, last_bit, load_ready}
    task automatic mb(input string tag, input logic [3:0] exp);
        chk({"msb ", tag}, {m_out, m_valid, m_last, m_ready}, exp);
    endtask

    task automatic lb(input string tag, input logic [3:0] exp);
        chk({"lsb ", tag}, {l_out, l_valid, l_last, l_ready}, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        mb("reset", 4'b0001);
        lb("reset", 4'b0001);
        @(negedge clk);
        rst = 1'b1;

        // Single word 1011 (LSB instance sees the same word)
        tick;
        load_valid = 1'b1;
        parallel_in = 4'b1011;
        #1 mb("t1 pre", 4'b0001);
        tick;
        load_valid = 1'b0;
        parallel_in = 4'b0000;
        #1 mb("t1 b1", 4'b1100); lb("t1 b1", 4'b1100);
        tick; #1 mb("t1 b2", 4'b0100); lb("t1 b2", 4'b1100);
        tick; #1 mb("t1 b3", 4'b1100); lb("t1 b3", 4'b0100);
        tick; #1 mb("t1 b4", 4'b1111); lb("t1 b4", 4'b1111);
        tick; #1 mb("t1 idle", 4'b0001); lb("t1 idle", 4'b0001);

        // Back-to-back 1011 then 0110, with SIPO loopback
        load_valid = 1'b1;
        parallel_in = 4'b1011;
        tick; #1 mb("bb w1b1", 4'b1100);
        tick; #1 mb("bb w1b2", 4'b0100);
        tick; #1 mb("bb w1b3", 4'b1100);
        tick; #1 mb("bb w1b4", 4'b1111);
        parallel_in = 4'b0110;
        tick; #1 mb("bb w2b1", 4'b0100);
        chk("sipo w1", sipo_q, 4'b1011);
        tick; #1 mb("bb w2b2", 4'b1100);
        tick; #1 mb("bb w2b3", 4'b1100);
        tick; #1 mb("bb w2b4", 4'b0111);
        load_valid = 1'b0;
        tick; #1 mb("bb idle", 4'b0001);
        chk("sipo w2", sipo_q, 4'b0110);

        // Busy rejection: 0011 offered for one cycle during bit 2 of 1100
        load_valid = 1'b1;
        parallel_in = 4'b1100;
        tick;
        load_valid = 1'b0;
        #1 mb("busy b1", 4'b1100);
        tick;
        load_valid = 1'b1;
        parallel_in = 4'b0011;
        #1 mb("busy b2", 4'b1100);
        tick;
        load_valid = 1'b0;
        parallel_in = 4'b0000;
        #1 mb("busy b3", 4'b0100);
        tick; #1 mb("busy b4", 4'b0111);
        tick; #1 mb("busy idle1", 4'b0001);
        tick; #1 mb("busy idle2", 4'b0001);

        // Reset mid-word, then a fresh 0101
        load_valid = 1'b1;
        parallel_in = 4'b1111;
        tick;
        load_valid = 1'b0;
        #1 mb("rm b1", 4'b1100);
        tick;
        #1 rst = 1'b0;
        #1 mb("rm async", 4'b0001); lb("rm async", 4'b0001);
        #2 rst = 1'b1;
        tick; #1 mb("rm idle", 4'b0001);
        load_valid = 1'b1;
        parallel_in = 4'b0101;
        tick;
        load_valid = 1'b0;
        #1 mb("rm n1", 4'b0100); lb("rm n1", 4'b1100);
        tick; #1 mb("rm n2", 4'b1100); lb("rm n2", 4'b0100);
        tick; #1 mb("rm n3", 4'b0100); lb("rm n3", 4'b1100);
        tick; #1 mb("rm n4", 4'b1111); lb("rm n4", 4'b0111);
        tick; #1 mb("rm idle2", 4'b0001);
        chk("sipo rm", sipo_q, 4'b0101);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
